// File: rtl/sop_term_engine.sv
// sop_term_engine: programmable sum-of-products evaluator.
// A table of N_TERMS product terms (care mask, polarity, enable) is written
// through a valid/ready port while idle. A start request samples an operand,
// the terms are evaluated one per cycle, and the per-term hits plus their OR
// are published with a one-cycle done pulse.
// Optional build macro SOP_TERM_COUNT_EN adds o_hit_count (number of matching
// terms), loaded together with o_term_hits.
module sop_term_engine #(
  parameter int N_IN    = 5,
  parameter int N_TERMS = 6,
  parameter int IDX_W   = (N_TERMS > 1) ? $clog2(N_TERMS) : 1,
  parameter int CNT_W   = $clog2(N_TERMS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [IDX_W-1:0]   i_cfg_idx,
  input  logic [N_IN-1:0]    i_cfg_care,
  input  logic [N_IN-1:0]    i_cfg_pol,
  input  logic               i_cfg_en,
  input  logic               i_start,
  input  logic [N_IN-1:0]    i_in_vec,
  output logic               o_busy,
  output logic               o_done,
  output logic [N_TERMS-1:0] o_term_hits,
`ifdef SOP_TERM_COUNT_EN
  output logic [CNT_W-1:0]   o_hit_count,
`endif
  output logic               o_sop_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [N_IN-1:0]      r_care [N_TERMS];
  logic [N_IN-1:0]      r_pol  [N_TERMS];
  logic [N_TERMS-1:0]   r_en;
  logic [N_IN-1:0]      r_operand;
  logic [N_TERMS-1:0]   r_scratch;
  logic [IDX_W-1:0]     r_cnt;
  logic [N_TERMS-1:0]   r_term_hits;
  logic                 r_sop;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_cfg_acc;
  logic                 w_cfg_wr;
  logic [N_IN-1:0]      w_diff;
  logic                 w_match;
  logic                 w_last;
  logic [N_TERMS-1:0]   w_scratch_next;

`ifdef SOP_TERM_COUNT_EN
  logic [CNT_W-1:0]     r_hit_count;

  function automatic logic [CNT_W-1:0] f_popcount(input logic [N_TERMS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_TERMS; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction
`endif

  // The table port is only open in IDLE; out-of-range indices complete the
  // handshake without touching the table.
  assign w_cfg_acc = i_cfg_valid & (r_state == S_IDLE);
  assign w_cfg_wr  = w_cfg_acc & (32'(i_cfg_idx) < 32'(N_TERMS));

  // ready is forced low while reset is held so no write is acknowledged then
  assign o_cfg_ready = rst_n & (r_state == S_IDLE);
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_term_hits = r_term_hits;
  assign o_sop_out   = r_sop;
`ifdef SOP_TERM_COUNT_EN
  assign o_hit_count = r_hit_count;
`endif

  // Evaluate the term selected by the counter and fold it into the scratch vector
  always_comb begin
    w_diff                = (r_operand ^ r_pol[r_cnt]) & r_care[r_cnt];
    w_match               = r_en[r_cnt] & (w_diff == '0);
    w_last                = (r_cnt == IDX_W'(N_TERMS - 1));
    w_scratch_next        = r_scratch;
    w_scratch_next[r_cnt] = w_match;
  end

  // Term table storage, written on an accepted in-range cfg handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TERMS; i++) begin
        r_care[i] <= '0;
        r_pol[i]  <= '0;
      end
      r_en <= '0;
    end else if (w_cfg_wr) begin
      r_care[i_cfg_idx] <= i_cfg_care;
      r_pol[i_cfg_idx]  <= i_cfg_pol;
      r_en[i_cfg_idx]   <= i_cfg_en;
    end else begin
      r_en <= r_en;
    end
  end

  // Control FSM with registered busy/done and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_operand   <= '0;
      r_scratch   <= '0;
      r_cnt       <= '0;
      r_term_hits <= '0;
      r_sop       <= 1'b0;
`ifdef SOP_TERM_COUNT_EN
      r_hit_count <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_operand <= i_in_vec;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_EVAL;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_EVAL: begin
          r_scratch <= w_scratch_next;
          if (w_last) begin
            // the last term's result is taken straight from the combinational path
            r_term_hits <= w_scratch_next;
            r_sop       <= |w_scratch_next;
`ifdef SOP_TERM_COUNT_EN
            r_hit_count <= f_popcount(w_scratch_next);
`endif
            r_done      <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + IDX_W'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sop_term_engine.sv
// Self-checking bench for sop_term_engine: directed scenarios plus random
// table writes and operands, checked against a bit-by-bit reference model.
module tb_sop_term_engine;
  localparam int N_IN    = 5;
  localparam int N_TERMS = 6;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_cfg_valid = 1'b0;
  logic               o_cfg_ready;
  logic [IDX_W-1:0]   i_cfg_idx = '0;
  logic [N_IN-1:0]    i_cfg_care = '0;
  logic [N_IN-1:0]    i_cfg_pol = '0;
  logic               i_cfg_en = 1'b0;
  logic               i_start = 1'b0;
  logic [N_IN-1:0]    i_in_vec = '0;
  logic               o_busy;
  logic               o_done;
  logic [N_TERMS-1:0] o_term_hits;
  logic               o_sop_out;
`ifdef SOP_TERM_COUNT_EN
  logic [CNT_W-1:0]   o_hit_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [N_IN-1:0]    m_care [N_TERMS];
  logic [N_IN-1:0]    m_pol  [N_TERMS];
  bit                 m_en   [N_TERMS];
  logic [N_TERMS-1:0] last_hits;

  sop_term_engine #(.N_IN(N_IN), .N_TERMS(N_TERMS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_idx   (i_cfg_idx),
    .i_cfg_care  (i_cfg_care),
    .i_cfg_pol   (i_cfg_pol),
    .i_cfg_en    (i_cfg_en),
    .i_start     (i_start),
    .i_in_vec    (i_in_vec),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_term_hits (o_term_hits),
`ifdef SOP_TERM_COUNT_EN
    .o_hit_count (o_hit_count),
`endif
    .o_sop_out   (o_sop_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N_TERMS; i++) begin
      m_care[i] = '0;
      m_pol[i]  = '0;
      m_en[i]   = 1'b0;
    end
  endfunction

  function automatic void model_write(input int idx, input logic [N_IN-1:0] care,
                                      input logic [N_IN-1:0] pol, input bit en);
    if (idx < N_TERMS) begin
      m_care[idx] = care;
      m_pol[idx]  = pol;
      m_en[idx]   = en;
    end
  endfunction

  // a term hits unless it is disabled or some cared-about bit disagrees
  function automatic logic [N_TERMS-1:0] model_hits(input logic [N_IN-1:0] v);
    logic [N_TERMS-1:0] h;
    h = '0;
    for (int i = 0; i < N_TERMS; i++) begin
      bit hit;
      hit = m_en[i];
      for (int b = 0; b < N_IN; b++) begin
        if (m_care[i][b] && (v[b] != m_pol[i][b])) hit = 1'b0;
      end
      h[i] = hit;
    end
    return h;
  endfunction

  task automatic cfg_write(input int idx, input logic [N_IN-1:0] care,
                           input logic [N_IN-1:0] pol, input bit en);
    @(negedge clk);
    chk("cfg_ready_idle", o_cfg_ready, 1);
    i_cfg_valid = 1'b1;
    i_cfg_idx   = idx[IDX_W-1:0];
    i_cfg_care  = care;
    i_cfg_pol   = pol;
    i_cfg_en    = en;
    model_write(idx, care, pol, en);
    @(posedge clk);
    @(negedge clk);
    i_cfg_valid = 1'b0;
  endtask

  // One evaluation; optionally a same-edge cfg write, optionally an
  // intruding start+cfg during EVAL which must be ignored.
  task automatic do_eval(input logic [N_IN-1:0] vec, input bit do_cfg, input int cidx,
                         input logic [N_IN-1:0] ccare, input logic [N_IN-1:0] cpol,
                         input bit cen, input bit intrude);
    logic [N_TERMS-1:0] exp_h;
    int lat;
    bit seen;
    int spurious;
    @(negedge clk);
    chk("ready_before_start", o_cfg_ready, 1);
    i_start  = 1'b1;
    i_in_vec = vec;
    if (do_cfg) begin
      i_cfg_valid = 1'b1;
      i_cfg_idx   = cidx[IDX_W-1:0];
      i_cfg_care  = ccare;
      i_cfg_pol   = cpol;
      i_cfg_en    = cen;
      model_write(cidx, ccare, cpol, cen);
    end
    exp_h = model_hits(vec);
    @(posedge clk);
    @(negedge clk);
    i_start     = 1'b0;
    i_cfg_valid = 1'b0;
    i_in_vec    = N_IN'($urandom);
    chk("busy_eval", o_busy, 1);
    chk("ready_eval", o_cfg_ready, 0);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (o_done) begin
        seen = 1'b1;
      end else begin
        if (intrude && lat == 3) begin
          chk("ready_intrude", o_cfg_ready, 0);
          i_start     = 1'b1;
          i_cfg_valid = 1'b1;
          i_cfg_idx   = 3'd1;
          i_cfg_care  = '0;
          i_cfg_pol   = '0;
          i_cfg_en    = 1'b1;
        end else begin
          i_start     = 1'b0;
          i_cfg_valid = 1'b0;
        end
        @(negedge clk);
        lat++;
        i_in_vec = N_IN'($urandom);
      end
    end
    i_start     = 1'b0;
    i_cfg_valid = 1'b0;
    chk("latency", lat, N_TERMS + 1);
    chk("term_hits", o_term_hits, exp_h);
    chk("sop_out", o_sop_out, |exp_h);
`ifdef SOP_TERM_COUNT_EN
    chk("hit_count", o_hit_count, $countones(exp_h));
`endif
    last_hits = exp_h;
    @(negedge clk);
    chk("done_pulse_width", o_done, 0);
    chk("busy_after", o_busy, 0);
    spurious = 0;
    for (int c = 0; c < N_TERMS + 2; c++) begin
      if (o_done || o_busy) spurious++;
      @(negedge clk);
    end
    chk("no_second_eval", spurious, 0);
    chk("hits_hold", o_term_hits, exp_h);
  endtask

  initial begin
    int spur;
    model_clear();
    last_hits = '0;
    #23;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ready", o_cfg_ready, 0);
    chk("rst_hits", o_term_hits, 0);
    chk("rst_sop", o_sop_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", o_cfg_ready, 1);

    // single term with mixed care/polarity
    cfg_write(0, 5'b11011, 5'b11010, 1'b1);
    do_eval(5'b11010, 1'b0, 0, '0, '0, 1'b0, 1'b0);
    chk("t27_hits", o_term_hits, 6'b000001);
    do_eval(5'b11011, 1'b0, 0, '0, '0, 1'b0, 1'b0);
    chk("t28_hits", o_term_hits, 6'b000000);

    // every term enabled with no cared bits always matches
    for (int i = 0; i < N_TERMS; i++) cfg_write(i, 5'b00000, 5'(i), 1'b1);
    do_eval(N_IN'($urandom), 1'b0, 0, '0, '0, 1'b0, 1'b0);
    chk("t29_hits", o_term_hits, 6'b111111);

    // start and cfg during EVAL are ignored
    cfg_write(1, 5'b00000, 5'b00000, 1'b0);
    do_eval(5'b10101, 1'b0, 0, '0, '0, 1'b0, 1'b1);
    chk("t30_bit1", o_term_hits[1], 0);

    // same-edge write and start: new entry is used
    cfg_write(2, 5'b00000, 5'b00000, 1'b0);
    do_eval(5'b00110, 1'b1, 2, 5'b00000, 5'b00000, 1'b1, 1'b0);
    chk("t32_bit2", o_term_hits[2], 1);

    // out-of-range index completes but changes nothing
    cfg_write(7, 5'b00000, 5'b00000, 1'b1);
    cfg_write(6, 5'b11111, 5'b00000, 1'b0);
    do_eval(5'b01100, 1'b0, 0, '0, '0, 1'b0, 1'b0);

    // random tables and operands
    for (int it = 0; it < 24; it++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        cfg_write($urandom_range(0, 7), N_IN'($urandom), N_IN'($urandom), bit'($urandom_range(0, 1)));
      end
      do_eval(N_IN'($urandom), bit'($urandom_range(0, 1)), $urandom_range(0, 7),
              N_IN'($urandom), N_IN'($urandom), bit'($urandom_range(0, 1)), 1'b0);
    end

    // reset in the middle of an evaluation
    cfg_write(0, 5'b00000, 5'b00000, 1'b1);
    do_eval(5'b00000, 1'b0, 0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    i_start  = 1'b1;
    i_in_vec = 5'b00000;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_done", o_done, 0);
    chk("midrst_hits", o_term_hits, 0);
    chk("midrst_sop", o_sop_out, 0);
    chk("midrst_ready", o_cfg_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    spur = 0;
    for (int c = 0; c < N_TERMS + 3; c++) begin
      @(negedge clk);
      if (o_done || o_busy) spur++;
    end
    chk("midrst_no_done", spur, 0);
    do_eval(N_IN'($urandom), 1'b0, 0, '0, '0, 1'b0, 1'b0);
    chk("table_cleared", o_term_hits, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
